// File: rtl/apb_rr_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | apb_rr_arbiter_if: requester handshake and APB master bundle             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface apb_rr_arbiter_if #(
  parameter int NB_REQ         = 4,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32
);
  localparam int c_strb_w = APB_DATA_WIDTH / 8;

  logic [NB_REQ-1:0]                     req_i;
  logic [NB_REQ-1:0][APB_ADDR_WIDTH-1:0] addr_i;
  logic [NB_REQ-1:0]                     we_i;
  logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0] wdata_i;
  logic [NB_REQ-1:0][c_strb_w-1:0]       be_i;
  logic [NB_REQ-1:0]                     gnt_o;
  logic [NB_REQ-1:0]                     rvalid_o;
  logic [APB_DATA_WIDTH-1:0]             rdata_o;
  logic                                  err_o;
  logic                                  busy_o;
  logic                                  psel_o;
  logic                                  penable_o;
  logic                                  pwrite_o;
  logic [APB_ADDR_WIDTH-1:0]             paddr_o;
  logic [APB_DATA_WIDTH-1:0]             pwdata_o;
  logic [c_strb_w-1:0]                   pstrb_o;
  logic [APB_DATA_WIDTH-1:0]             prdata_i;
  logic                                  pready_i;
  logic                                  pslverr_i;

  // The arbiter owns the APB master side of the bundle.
  modport master (
    input  req_i, addr_i, we_i, wdata_i, be_i, prdata_i, pready_i, pslverr_i,
    output gnt_o, rvalid_o, rdata_o, err_o, busy_o,
           psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o
  );

  modport slave (
    output req_i, addr_i, we_i, wdata_i, be_i, prdata_i, pready_i, pslverr_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, busy_o,
           psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o
  );
endinterface

`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | apb_rr_arbiter: round-robin sharing of one APB master port, with timeout |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module apb_rr_arbiter #(
  parameter int NB_REQ         = 4,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT        = 255
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  apb_rr_arbiter_if.master  bus
);
  localparam int c_ptr_w  = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int c_strb_w = APB_DATA_WIDTH / 8;
  localparam int c_cnt_w  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_setup  = 2'd1;
  localparam logic [1:0] c_access = 2'd2;

  logic [1:0]                r_state;
  logic [1:0]                w_state_next;
  logic [c_ptr_w-1:0]        r_ptr;
  logic [c_ptr_w-1:0]        r_owner;
  logic [c_ptr_w-1:0]        w_winner;
  logic [c_ptr_w-1:0]        w_ptr_next;
  logic                      w_found;
  int                        w_idx;
  logic [c_cnt_w-1:0]        r_cnt;
  logic                      w_complete;
  logic                      w_timeout;
  logic                      r_pwrite;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [APB_DATA_WIDTH-1:0] r_pwdata;
  logic [c_strb_w-1:0]       r_pstrb;
  logic [NB_REQ-1:0]         r_rvalid;
  logic [APB_DATA_WIDTH-1:0] r_rdata;
  logic                      r_err;

  // Search starts at the pointer and wraps, so the first hit is the RR winner.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int i = 0; i < NB_REQ; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NB_REQ) w_idx = w_idx - NB_REQ;
      if (!w_found && bus.req_i[w_idx]) begin
        w_found  = 1'b1;
        w_winner = c_ptr_w'(w_idx);
      end
    end
  end

  assign w_ptr_next = (w_winner == c_ptr_w'(NB_REQ - 1)) ? '0 : w_winner + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= c_idle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_complete   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      c_idle:   if (w_found) w_state_next = c_setup;
      c_setup:  w_state_next = c_access;
      c_access: begin
        if (bus.pready_i) begin
          w_complete   = 1'b1;
          w_state_next = c_idle;
        end else if ((TIMEOUT != 0) && (r_cnt == c_cnt_w'(TIMEOUT - 1))) begin
          w_complete   = 1'b1;
          w_timeout    = 1'b1;
          w_state_next = c_idle;
        end
      end
      default:  w_state_next = c_idle;
    endcase
  end

  always_comb begin
    bus.gnt_o     = '0;
    bus.busy_o    = 1'b0;
    bus.psel_o    = (r_state == c_setup) || (r_state == c_access);
    bus.penable_o = (r_state == c_access);
    if (!rst_i) begin
      bus.busy_o = (r_state != c_idle);
      if ((r_state == c_idle) && w_found) bus.gnt_o[w_winner] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr    <= '0;
      r_owner  <= '0;
      r_cnt    <= '0;
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pstrb  <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= '0;
      if ((r_state == c_idle) && w_found) begin
        r_ptr    <= w_ptr_next;
        r_owner  <= w_winner;
        r_pwrite <= bus.we_i[w_winner];
        r_paddr  <= bus.addr_i[w_winner];
        r_pwdata <= bus.wdata_i[w_winner];
        r_pstrb  <= bus.we_i[w_winner] ? bus.be_i[w_winner] : '0;
      end
      if ((TIMEOUT != 0) && (r_state == c_access) && !w_complete) r_cnt <= r_cnt + 1'b1;
      else                                                         r_cnt <= '0;
      if (w_complete) begin
        r_rvalid <= {{(NB_REQ-1){1'b0}}, 1'b1} << r_owner;
        r_err    <= w_timeout | bus.pslverr_i;
        r_rdata  <= (!w_timeout && !r_pwrite) ? bus.prdata_i : '0;
      end
    end
  end

  assign bus.pwrite_o = r_pwrite;
  assign bus.paddr_o  = r_paddr;
  assign bus.pwdata_o = r_pwdata;
  assign bus.pstrb_o  = r_pstrb;
  assign bus.rvalid_o = r_rvalid;
  assign bus.rdata_o  = r_rdata;
  assign bus.err_o    = r_err;
endmodule

`default_nettype wire

// File: tb/tb_apb_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_apb_rr_arbiter: scoreboard bench with transaction-level arbiter model |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_apb_rr_arbiter;
  localparam int NB = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_rr_arbiter_if #(.NB_REQ(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus ();

  apb_rr_arbiter #(.NB_REQ(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    int          owner;
    logic [DW-1:0] rdata;
    logic        err;
    longint      cyc;
  } exp_t;

  exp_t   sb[$];
  longint cyc = 0;
  int     n_vec = 0;
  int     n_err = 0;

  // Reference model: pointer, and the cycle window of the outstanding transfer.
  int     m_ptr = 0;
  longint g_cyc = -1;
  longint idle_at = 0;
  logic [AW-1:0] cur_addr;
  logic          cur_we;
  logic [DW-1:0] cur_wdata;
  logic [SW-1:0] cur_be;
  logic [DW-1:0] cur_rd;
  logic          cur_perr;
  int            cur_w;
  int            acc_n = 0;

  int       f_wait = -1;
  int       f_err = -1;
  bit       f_rd_en = 1'b0;
  logic [DW-1:0] f_rd = '0;
  bit       auto_rereq = 1'b0;
  bit       rand_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] be);
    bus.req_i[i]   = 1'b1;
    bus.we_i[i]    = we;
    bus.addr_i[i]  = a;
    bus.wdata_i[i] = d;
    bus.be_i[i]    = be;
  endtask

  task automatic rand_req(input int i);
    set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom, SW'($urandom_range(0, 15)));
  endtask

  // One clock: check and model at the negedge, update requesters after the posedge.
  task automatic step();
    int pick;
    int acc;
    int idx;
    logic [NB-1:0] exp_g;
    exp_t e;
    pick = -1;
    @(negedge clk);
    if (rst) begin
      chk("gnt_in_reset", bus.gnt_o, 0);
      chk("busy_in_reset", bus.busy_o, 0);
      bus.pready_i = 1'b0;
    end else begin
      chk("busy", bus.busy_o, (cyc > g_cyc) && (cyc < idle_at));
      chk("psel", bus.psel_o, (cyc > g_cyc) && (cyc < idle_at));
      chk("penable", bus.penable_o, (cyc > g_cyc + 1) && (cyc < idle_at));
      if (bus.psel_o && !bus.penable_o) begin
        chk("paddr", bus.paddr_o, cur_addr);
        chk("pwrite", bus.pwrite_o, cur_we);
        chk("pwdata", bus.pwdata_o, cur_wdata);
        chk("pstrb", bus.pstrb_o, cur_we ? cur_be : '0);
      end
      if (bus.psel_o && bus.penable_o) begin
        acc_n++;
        chk("paddr_hold", bus.paddr_o, cur_addr);
        if (acc_n == cur_w + 1) begin
          bus.pready_i  = 1'b1;
          bus.prdata_i  = cur_rd;
          bus.pslverr_i = cur_perr;
        end else begin
          bus.pready_i  = 1'b0;
          bus.prdata_i  = $urandom;
          bus.pslverr_i = 1'($urandom_range(0, 1));
        end
      end else begin
        acc_n         = 0;
        bus.pready_i  = 1'($urandom_range(0, 1));
        bus.prdata_i  = $urandom;
        bus.pslverr_i = 1'($urandom_range(0, 1));
      end
      if (cyc >= idle_at) begin
        for (int k = 0; k < NB; k++) begin
          idx = (m_ptr + k) % NB;
          if (pick < 0 && bus.req_i[idx]) pick = idx;
        end
      end
      exp_g = (pick >= 0) ? (NB'(1) << pick) : '0;
      chk("gnt", bus.gnt_o, exp_g);
      if (pick >= 0) begin
        cur_addr  = bus.addr_i[pick];
        cur_we    = bus.we_i[pick];
        cur_wdata = bus.wdata_i[pick];
        cur_be    = bus.be_i[pick];
        cur_w     = (f_wait >= 0) ? f_wait : $urandom_range(0, 5);
        cur_perr  = (f_err >= 0) ? 1'(f_err) : ($urandom_range(0, 3) == 0);
        cur_rd    = f_rd_en ? f_rd : $urandom;
        acc       = (cur_w >= TO) ? TO : cur_w + 1;
        e.owner   = pick;
        e.err     = (cur_w >= TO) ? 1'b1 : cur_perr;
        e.rdata   = ((cur_w >= TO) || cur_we) ? '0 : cur_rd;
        e.cyc     = cyc + 2 + acc;
        sb.push_back(e);
        g_cyc   = cyc;
        idle_at = e.cyc;
        m_ptr   = (pick + 1) % NB;
      end
    end
    @(posedge clk);
    #1;
    if (pick >= 0) begin
      if (auto_rereq) rand_req(pick);
      else            bus.req_i[pick] = 1'b0;
    end
    if (rand_mode) begin
      for (int i = 0; i < NB; i++) begin
        if (i != pick) begin
          if (!bus.req_i[i]) begin
            if ($urandom_range(0, 3) == 0) rand_req(i);
          end else if ($urandom_range(0, 19) == 0) begin
            bus.req_i[i] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_i = '0;
    step();
    rst = 1'b0;
    m_ptr = 0; g_cyc = -1; idle_at = 0; acc_n = 0;
    sb.delete();
    @(negedge clk);
    chk("rst_psel", bus.psel_o, 0);
    chk("rst_penable", bus.penable_o, 0);
    chk("rst_pwrite", bus.pwrite_o, 0);
    chk("rst_paddr", bus.paddr_o, 0);
    chk("rst_pwdata", bus.pwdata_o, 0);
    chk("rst_pstrb", bus.pstrb_o, 0);
    chk("rst_rvalid", bus.rvalid_o, 0);
    chk("rst_rdata", bus.rdata_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_gnt", bus.gnt_o, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.req_i != '0 || cyc < idle_at) && n < 80) begin
      step();
      n++;
    end
    chk("drain_bound", n >= 80, 0);
  endtask

  // Monitor: every rvalid pulse pops one expected completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.rvalid_o != '0) begin
          if (sb.size() == 0) begin
            chk("rvalid_unexpected", bus.rvalid_o, 0);
          end else begin
            e = sb.pop_front();
            chk("rvalid_cycle", cyc, e.cyc);
            chk("rvalid_owner", bus.rvalid_o, NB'(1) << e.owner);
            chk("rdata", bus.rdata_o, e.rdata);
            chk("err", bus.err_o, e.err);
          end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front();
          chk("rvalid_missing", bus.rvalid_o, NB'(1) << e.owner);
        end
      end
    end
  end

  initial begin
    bus.req_i = '0; bus.we_i = '0; bus.addr_i = '0; bus.wdata_i = '0; bus.be_i = '0;
    bus.prdata_i = '0; bus.pready_i = 1'b0; bus.pslverr_i = 1'b0;
    do_reset();

    // Single zero-wait write
    f_wait = 0; f_err = 0;
    set_req(0, 1'b1, 32'h1A10_0004, 32'hDEAD_BEEF, 4'hF);
    drain();

    // Read with two wait states
    f_wait = 2; f_rd_en = 1'b1; f_rd = 32'h1234_5678;
    set_req(2, 1'b0, 32'h1A10_0100, 32'hFFFF_FFFF, 4'hF);
    drain();
    f_rd_en = 1'b0;

    // All requesters continuously requesting from reset
    do_reset();
    f_wait = 0; f_err = -1; auto_rereq = 1'b1;
    for (int i = 0; i < NB; i++) rand_req(i);
    repeat (30) step();
    auto_rereq = 1'b0;
    drain();

    // Slave error
    f_wait = 1; f_err = 1;
    set_req(3, 1'b1, 32'h0000_0040, 32'h5555_AAAA, 4'h3);
    drain();

    // Timeout, then a normal transfer
    f_wait = 9; f_err = 0;
    set_req(1, 1'b0, 32'h0000_0080, 32'h0, 4'hF);
    drain();
    f_wait = 0;
    set_req(0, 1'b0, 32'h0000_0084, 32'h0, 4'hF);
    drain();

    // Reset while in ACCESS, then simultaneous requests 1010
    f_wait = 9;
    set_req(2, 1'b1, 32'h0000_00C0, 32'hCAFE_F00D, 4'hF);
    repeat (3) step();
    do_reset();
    f_wait = 0;
    rand_req(1);
    rand_req(3);
    drain();

    // Randomized traffic
    f_wait = -1; f_err = -1; rand_mode = 1'b1;
    repeat (2000) step();
    rand_mode = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
